// File: rtl/matrix_mult_scheduler.sv
// matrix_mult_scheduler
//   Sequencer for one shared vector-multiply datapath computing C = A * B
//   (A is L x M, B is M x N, C is L x N, all row-major fp32 words). On an
//   accepted start it snapshots A and B (B stored transposed), presents one
//   row/column operand pair per output element for VM_LATENCY cycles, stores
//   the returned dot product into result and pulses done.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request a new multiplication; accepted only while idle
//   A, B       input matrices, row-major
//   res_scalar dot product returned by the vector multiplier
//   A_vector   current row of the A snapshot (registered)
//   B_vector   current column of the B snapshot, contiguous (registered)
//   row_idx    current output row
//   col_idx    current output column
//   busy       high while the run is in progress
//   done       one-cycle pulse when result is complete
//   result     matrix C, element (r,c) at [32*(N*r+c) +: 32]
//
// Configuration
//   MATMUL_SCHED_RELU_EN  when defined, captured words with bit 31 set are
//                         stored as zero (fused ReLU); timing is unchanged.
module matrix_mult_scheduler #(
  parameter int unsigned L          = 1,
  parameter int unsigned M          = 1,
  parameter int unsigned N          = 1,
  parameter int unsigned VM_LATENCY = 1,
  localparam int unsigned RowW      = (L > 1) ? $clog2(L) : 1,
  localparam int unsigned ColW      = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned WaitW     = (VM_LATENCY > 1) ? $clog2(VM_LATENCY) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [32*L*M-1:0]     A,
  input  logic [32*M*N-1:0]     B,
  input  logic [31:0]           res_scalar,
  output logic [32*M-1:0]       A_vector,
  output logic [32*M-1:0]       B_vector,
  output logic [RowW-1:0]       row_idx,
  output logic [ColW-1:0]       col_idx,
  output logic                  busy,
  output logic                  done,
  output logic [32*L*N-1:0]     result
);

  localparam logic [WaitW-1:0] WaitReload = WaitW'(VM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q;
  logic [32*L*M-1:0]   a_snap_q;
  logic [32*M*N-1:0]   bt_snap_q;
  logic [32*M-1:0]     a_vec_q, b_vec_q;
  logic [RowW-1:0]     row_q;
  logic [ColW-1:0]     col_q;
  logic [WaitW-1:0]    wait_q;
  logic                busy_q, done_q;
  logic [32*L*N-1:0]   result_q;

  logic [32*M*N-1:0]   bt_in;
  logic                last_row, last_col;
  logic [RowW-1:0]     nxt_row;
  logic [ColW-1:0]     nxt_col;
  logic [32*M-1:0]     a_next, b_next;
  logic [31:0]         cap;
  logic [32*L*N-1:0]   result_upd;

  // Column c of B becomes the contiguous slice [32*M*c +: 32*M].
  function automatic logic [32*M*N-1:0] transpose(input logic [32*M*N-1:0] b);
    logic [32*M*N-1:0] t;
    t = '0;
    for (int unsigned k = 0; k < M; k++) begin
      for (int unsigned c = 0; c < N; c++) begin
        t[32*(M*c+k) +: 32] = b[32*(N*k+c) +: 32];
      end
    end
    return t;
  endfunction

  always_comb begin
    bt_in    = transpose(B);
    last_row = (row_q == RowW'(L - 1));
    last_col = (col_q == ColW'(N - 1));
    nxt_col  = last_col ? '0 : col_q + ColW'(1);
    nxt_row  = last_col ? row_q + RowW'(1) : row_q;

    a_next = '0;
    for (int unsigned r = 0; r < L; r++) begin
      if (nxt_row == RowW'(r)) a_next = a_snap_q[32*M*r +: 32*M];
    end
    b_next = '0;
    for (int unsigned c = 0; c < N; c++) begin
      if (nxt_col == ColW'(c)) b_next = bt_snap_q[32*M*c +: 32*M];
    end

`ifdef MATMUL_SCHED_RELU_EN
    cap = res_scalar[31] ? 32'h0 : res_scalar;
`else
    cap = res_scalar;
`endif

    result_upd = result_q;
    for (int unsigned r = 0; r < L; r++) begin
      for (int unsigned c = 0; c < N; c++) begin
        if (row_q == RowW'(r) && col_q == ColW'(c)) result_upd[32*(N*r+c) +: 32] = cap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_snap_q  <= '0;
      bt_snap_q <= '0;
      a_vec_q   <= '0;
      b_vec_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wait_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= StRun;
            busy_q    <= 1'b1;
            a_snap_q  <= A;
            bt_snap_q <= bt_in;
            result_q  <= '0;
            row_q     <= '0;
            col_q     <= '0;
            // Snapshot is not yet valid this edge, so element (0,0) comes from the inputs.
            a_vec_q   <= A[32*M-1:0];
            b_vec_q   <= bt_in[32*M-1:0];
            wait_q    <= WaitReload;
          end
        end
        StRun: begin
          if (wait_q != '0) begin
            wait_q <= wait_q - WaitW'(1);
          end else begin
            result_q <= result_upd;
            if (last_row && last_col) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              row_q   <= nxt_row;
              col_q   <= nxt_col;
              a_vec_q <= a_next;
              b_vec_q <= b_next;
              wait_q  <= WaitReload;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign A_vector = a_vec_q;
  assign B_vector = b_vec_q;
  assign row_idx  = row_q;
  assign col_idx  = col_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule
